uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter, successor to the fixed 8N1 transmitter. Bytes are written through a valid/ready handshake into an internal FIFO. Frames go out with a runtime-selectable baud divisor, character length (5-8 bits), parity (none/even/odd) and stop bits (1/2). It sits between the board-level command/debug logic and the FPGA TX pin.

Parameters:
CLOCK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 9600, baud rate used when cfg_div == 0
FIFO_DEPTH, 8, transmit FIFO entries; power of two, >= 2
DIV_WIDTH, 16, width of cfg_div

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_data  in  8  byte to send; bits above the character length are ignored
in_valid  in  1  in_data is offered
in_ready  out  1  FIFO can accept; a push occurs when in_valid && in_ready
cfg_div  in  DIV_WIDTH  clock cycles per bit; 0 selects CLOCK_FREQ/BAUD_RATE
cfg_nbits  in  2  character length: 00=5, 01=6, 10=7, 11=8
cfg_parity  in  2  00=none, 01=even, 10=odd, 11=none
cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits
tx  out  1  serial line, idle high
tx_busy  out  1  high while a frame is in progress or the FIFO is non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset is asynchronous, active-low, and valid at any time, including mid-frame.
  - On reset: tx=1, tx_busy=0, in_ready=1, fifo_count=0, FIFO emptied, state IDLE, all counters 0.
  - A frame cut by reset is abandoned; tx returns high immediately.
- FIFO:
  - in_ready = (fifo_count != FIFO_DEPTH).
  - A push when full is impossible by the handshake.
  - A simultaneous push and pop leaves fifo_count unchanged; a push into a full FIFO in the same cycle as a pop is still refused (in_ready is low).
  - Pointers wrap modulo FIFO_DEPTH.
- Bit period P:
  - P = cfg_div when cfg_div >= 2.
  - cfg_div == 1 is treated as P = 2.
  - cfg_div == 0 gives P = CLOCK_FREQ/BAUD_RATE.
- Configuration is latched when a frame starts (the pop cycle). Changes to cfg_* during a frame do not affect that frame.
- Data bit 0 is the LSB. Even parity = XOR of the N transmitted data bits; odd parity = the inverse of that.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. When the FIFO is non-empty: pop, latch data and config, go to START. The first START cycle on tx is the cycle after the pop.
  - START: tx=0 for P cycles -> DATA.
  - DATA: tx=shift[0] for P cycles per bit, N bits. Then PARITY if parity is enabled, else STOP.
  - PARITY: parity bit for P cycles -> STOP.
  - STOP: tx=1 for P cycles, or 2P if cfg_stop2 was latched.
    - On the last stop cycle, if the FIFO is non-empty, pop and go to START. The next start bit begins on the following cycle, so there is no idle gap.
    - Otherwise go to IDLE.
- Frame length = (1 + N + parity + stop) * P cycles exactly.
- tx is registered: no glitches, and tx changes only on bit boundaries.
- tx_busy = (state != IDLE) || (fifo_count != 0), registered. It falls in the cycle after the final stop bit completes with the FIFO empty.

Test Plan:
- Reset, then push 0x55 with cfg_div=4, 8N1 -> in the cycle after the pop, tx = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles (frame 40 cycles); tx_busy high throughout, low afterwards.
- 0x07, 8 bits, even parity, div=4 -> parity bit = 1; with odd parity -> parity bit = 0; frame = 44 cycles.
- 0xFF, cfg_nbits=00, no parity, cfg_stop2=1, div=3 -> start, five 1 data bits, two stop bits; frame = 24 cycles; bits 7:5 never appear on tx.
- Push 10 bytes back-to-back with FIFO_DEPTH=8 and div=2 -> in_ready drops once 8 are buffered; every byte is transmitted in order with no idle cycle between frames; fifo_count tracks occupancy, including a simultaneous push and pop.
- Change cfg_div from 4 to 8 and cfg_parity mid-frame -> the current frame keeps div=4 and no parity; the next frame uses the new settings. With cfg_div=0, the bit period is CLOCK_FREQ/BAUD_RATE.
- Assert rst_n low in the middle of the DATA state -> tx=1, tx_busy=0 and fifo_count=0 immediately (asynchronously); after release, a new push transmits normally.

Source files
------------

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_cfg
//  Description : Runtime-configurable UART transmitter with a transmit FIFO.
//                Selectable baud divisor, 5-8 data bits, none/even/odd
//                parity and one or two stop bits. Each frame's settings are
//                captured when its byte leaves the FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int CLOCK_FREQ = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DIV_WIDTH-1:0]          cfg_div,
    input  logic [1:0]                    cfg_nbits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [DIV_WIDTH-1:0] c_DEFAULT_DIV = DIV_WIDTH'(CLOCK_FREQ / BAUD_RATE);
    localparam logic [c_CW-1:0]      c_FULL        = c_CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;

    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_period;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [2:0]           r_bit;
    logic [2:0]           r_last_data;
    logic [7:0]           r_shift;
    logic                 r_par_en;
    logic                 r_par_bit;
    logic                 r_stop2;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_stop_done;
    logic                 w_go_idle;
    logic [c_CW-1:0]      w_count_next;
    logic [DIV_WIDTH-1:0] w_period;
    logic [7:0]           w_head;
    logic [7:0]           w_mask;
    logic                 w_par;

    assign in_ready    = (fifo_count != c_FULL);
    assign w_push      = in_valid && in_ready;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_bit_end   = (r_cnt == r_period - 1'b1);
    // Last cycle of the last stop bit: bit index 0 for one stop, 1 for two.
    assign w_stop_done = (r_state == S_STOP) && w_bit_end && (r_bit == {2'b00, r_stop2});
    // A byte is taken when idle or exactly at the end of a frame, giving no gap.
    assign w_pop       = (fifo_count != '0) && ((r_state == S_IDLE) || w_stop_done);
    assign w_go_idle   = !w_pop && ((r_state == S_IDLE) || w_stop_done);
    // Only the low N bits of the byte contribute to parity.
    assign w_mask      = 8'hFF >> (2'd3 - cfg_nbits);
    assign w_par       = (^(w_head & w_mask)) ^ (cfg_parity == 2'b10);

    // Effective bit period: 0 selects the default rate, 1 is raised to 2.
    always_comb begin
        w_period = cfg_div;
        if (cfg_div == '0) begin
            w_period = c_DEFAULT_DIV;
        end else if (cfg_div == DIV_WIDTH'(1)) begin
            w_period = DIV_WIDTH'(2);
        end
    end

    // Next FIFO occupancy; a simultaneous push and pop cancel out.
    always_comb begin
        w_count_next = fifo_count;
        if (w_push && !w_pop) begin
            w_count_next = fifo_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = fifo_count - 1'b1;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            fifo_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            fifo_count <= w_count_next;
        end
    end

    // Frame sequencer with registered tx and busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_period    <= '0;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_last_data <= '0;
            r_shift     <= '0;
            r_par_en    <= 1'b0;
            r_par_bit   <= 1'b0;
            r_stop2     <= 1'b0;
            tx          <= 1'b1;
            tx_busy     <= 1'b0;
        end else begin
            tx_busy <= !w_go_idle || (w_count_next != '0);
            if (w_pop) begin
                // Capture byte and settings; start bit appears next cycle.
                r_shift     <= w_head;
                r_period    <= w_period;
                r_last_data <= {1'b1, cfg_nbits};
                r_par_en    <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
                r_par_bit   <= w_par;
                r_stop2     <= cfg_stop2;
                r_cnt       <= '0;
                r_bit       <= '0;
                r_state     <= S_START;
                tx          <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        tx <= 1'b1;
                    end
                    S_START: begin
                        if (w_bit_end) begin
                            r_cnt   <= '0;
                            r_bit   <= '0;
                            r_state <= S_DATA;
                            tx      <= r_shift[0];
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (w_bit_end) begin
                            r_cnt   <= '0;
                            r_shift <= r_shift >> 1;
                            if (r_bit == r_last_data) begin
                                r_bit <= '0;
                                if (r_par_en) begin
                                    r_state <= S_PARITY;
                                    tx      <= r_par_bit;
                                end else begin
                                    r_state <= S_STOP;
                                    tx      <= 1'b1;
                                end
                            end else begin
                                r_bit <= r_bit + 1'b1;
                                tx    <= r_shift[1];
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (w_bit_end) begin
                            r_cnt   <= '0;
                            r_bit   <= '0;
                            r_state <= S_STOP;
                            tx      <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (w_bit_end) begin
                            r_cnt <= '0;
                            if (w_stop_done) begin
                                r_state <= S_IDLE;
                                tx      <= 1'b1;
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        tx      <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_cfg
//  Description : Self-checking bench for uart_tx_cfg. Expected line activity
//                is built from frame rules (start, LSB-first data, parity,
//                stop bits) as a list of bit levels held for P cycles each.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    localparam int CF    = 1000000;
    localparam int BR    = 100000;
    localparam int DEPTH = 8;
    localparam int DW    = 16;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [7:0]                 in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic [DW-1:0]              cfg_div;
    logic [1:0]                 cfg_nbits;
    logic [1:0]                 cfg_parity;
    logic                       cfg_stop2;
    logic                       tx;
    logic                       tx_busy;
    logic [$clog2(DEPTH):0]     fifo_count;

    int checks = 0;
    int errors = 0;

    uart_tx_cfg #(
        .CLOCK_FREQ (CF),
        .BAUD_RATE  (BR),
        .FIFO_DEPTH (DEPTH),
        .DIV_WIDTH  (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cfg_div    (cfg_div),
        .cfg_nbits  (cfg_nbits),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int div, input int nb_code, input int par, input int st2);
        cfg_div    = DW'(div);
        cfg_nbits  = 2'(nb_code);
        cfg_parity = 2'(par);
        cfg_stop2  = 1'(st2);
    endtask

    // Model of the settings currently driven onto the cfg inputs.
    function automatic int model_p();
        if (cfg_div == 0) return CF / BR;
        if (cfg_div == 1) return 2;
        return int'(cfg_div);
    endfunction
    function automatic int model_nb();
        return int'(cfg_nbits) + 5;
    endfunction
    function automatic int model_par();
        if (cfg_parity == 2'd1) return 1;
        if (cfg_parity == 2'd2) return 2;
        return 0;
    endfunction
    function automatic int model_st();
        return cfg_stop2 ? 2 : 1;
    endfunction

    // Offer one byte, holding valid until accepted; call just after a falling edge.
    task automatic push(input logic [7:0] d);
        int w = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("push ready timeout", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Check one frame cycle by cycle. immediate=1: the start bit must be on
    // the very next sample; otherwise wait (bounded) for the start bit.
    task automatic expect_frame(input logic [7:0] d, input int nb, input int par,
                                input int st, input int p, input bit immediate,
                                input string tag);
        logic       bits[$];
        int         ones = 0;
        int         waited = 0;
        logic [1:0] obs;
        bit         bad;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par == 1) bits.push_back(logic'(ones % 2));
        if (par == 2) bits.push_back(logic'(1 - (ones % 2)));
        for (int i = 0; i < st; i++) bits.push_back(1'b1);
        @(negedge clk);
        if (!immediate) begin
            while (tx !== 1'b0 && waited < 2000) begin
                @(negedge clk);
                waited++;
            end
            if (tx !== 1'b0) begin
                chk({tag, " start timeout"}, 32'(tx), 0);
                return;
            end
        end
        for (int i = 0; i < bits.size(); i++) begin
            bad = 1'b0;
            obs = 2'b00;
            for (int c = 0; c < p; c++) begin
                if (i != 0 || c != 0) @(negedge clk);
                if (!bad) obs = {tx_busy, tx};
                if (tx !== bits[i] || tx_busy !== 1'b1) bad = 1'b1;
            end
            chk($sformatf("%s bit%0d busy,tx", tag, i), 32'(obs), 32'({1'b1, bits[i]}));
        end
    endtask

    // Push one byte while idle and check its frame plus return to idle.
    task automatic send_and_check(input logic [7:0] d, input string tag);
        push(d);
        expect_frame(d, model_nb(), model_par(), model_st(), model_p(), 1'b1, tag);
        @(negedge clk);
        chk({tag, " idle busy"}, 32'(tx_busy), 0);
        chk({tag, " idle tx"}, 32'(tx), 1);
    endtask

    initial begin
        logic [7:0] bytes[10];
        logic [7:0] a;
        logic [7:0] b;
        in_valid = 1'b0;
        in_data  = 8'h00;
        set_cfg(4, 3, 0, 0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset tx", 32'(tx), 1);
        chk("reset busy", 32'(tx_busy), 0);
        chk("reset ready", 32'(in_ready), 1);
        chk("reset count", 32'(fifo_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 0x55 8N1 div 4, including latency from push to start bit
        push(8'h55);
        chk("t1 count", 32'(fifo_count), 1);
        chk("t1 busy", 32'(tx_busy), 1);
        chk("t1 tx idle", 32'(tx), 1);
        expect_frame(8'h55, 8, 0, 1, 4, 1'b1, "t1");
        @(negedge clk);
        chk("t1 busy after", 32'(tx_busy), 0);
        chk("t1 tx after", 32'(tx), 1);

        // Parity
        set_cfg(4, 3, 1, 0);
        send_and_check(8'h07, "t2 even");
        set_cfg(4, 3, 2, 0);
        send_and_check(8'h07, "t2 odd");

        // 5 bits, two stops, div 3; then div 1 with parity code 11
        set_cfg(3, 0, 0, 1);
        send_and_check(8'hFF, "t3 5n2");
        set_cfg(1, 1, 3, 0);
        send_and_check(8'($urandom), "t3 div1");

        // Ten bytes back to back, div 2
        set_cfg(2, 3, 0, 0);
        for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
        fork
            begin
                push(bytes[0]);
                push(bytes[1]);
                chk("t4 push+pop count", 32'(fifo_count), 1);
                for (int i = 2; i < 9; i++) push(bytes[i]);
                chk("t4 full count", 32'(fifo_count), DEPTH);
                chk("t4 full ready", 32'(in_ready), 0);
                push(bytes[9]);
                chk("t4 refill count", 32'(fifo_count), DEPTH);
            end
            begin
                expect_frame(bytes[0], 8, 0, 1, 2, 1'b0, "t4 f0");
                for (int i = 1; i < 10; i++)
                    expect_frame(bytes[i], 8, 0, 1, 2, 1'b1, $sformatf("t4 f%0d", i));
            end
        join
        @(negedge clk);
        chk("t4 end busy", 32'(tx_busy), 0);
        chk("t4 end count", 32'(fifo_count), 0);

        // Mid-frame configuration change affects only the next frame
        set_cfg(4, 3, 0, 0);
        a = 8'($urandom);
        b = 8'($urandom);
        fork
            begin
                push(a);
                push(b);
                repeat (10) @(negedge clk);
                set_cfg(8, 3, 1, 0);
            end
            begin
                expect_frame(a, 8, 0, 1, 4, 1'b0, "t5 old");
                expect_frame(b, 8, 1, 1, 8, 1'b1, "t5 new");
            end
        join
        @(negedge clk);
        chk("t5 end busy", 32'(tx_busy), 0);
        set_cfg(0, 3, 0, 0);
        send_and_check(8'($urandom), "t5 div0");

        // Randomized settings
        for (int k = 0; k < 6; k++) begin
            set_cfg(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
            send_and_check(8'($urandom), $sformatf("rnd%0d", k));
        end

        // Asynchronous reset in the middle of DATA (bit 1 is low)
        set_cfg(4, 3, 0, 0);
        push(8'($urandom) & 8'hF0);
        push(8'($urandom));
        repeat (10) @(negedge clk);
        chk("t6 pre count", 32'(fifo_count), 1);
        chk("t6 pre tx", 32'(tx), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 async tx", 32'(tx), 1);
        chk("t6 async busy", 32'(tx_busy), 0);
        chk("t6 async count", 32'(fifo_count), 0);
        chk("t6 async ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6 stays idle", 32'({tx_busy, tx}), 32'(2'b01));
        send_and_check(8'($urandom), "t6 after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
